// File: rtl/ram_2p_pkg.sv
// Shared types, collision-mode constants and bit-mask merge helper for ram_2p_bm_pipe.
package ram_2p_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int unsigned RW_READ_FIRST    = 0;
    localparam int unsigned RW_WRITE_THROUGH = 1;

    // Widest word the merge helper handles; callers cast to/from their own width.
    localparam int unsigned MERGE_W = 256;
    typedef logic [MERGE_W-1:0] merge_word_t;

    function automatic merge_word_t merge_bm(input merge_word_t old_word,
                                             input merge_word_t dw,
                                             input merge_word_t bm);
        return (old_word & ~bm) | (dw & bm);
    endfunction

endpackage

// File: rtl/ram_2p_out_pipe.sv
// Data+valid register chain of configurable depth; data only advances with its valid,
// so the last stage holds the most recent completed read.
module ram_2p_out_pipe #(
    parameter int unsigned P_DATA_WIDTH = 20,
    parameter int unsigned P_DEPTH      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_DATA_WIDTH-1:0] src_data,
    input  logic                    src_valid,
    output logic [P_DATA_WIDTH-1:0] dst_data,
    output logic                    dst_valid
);

    generate
        if (P_DEPTH == 0) begin : g_bypass
            assign dst_data  = src_data;
            assign dst_valid = src_valid;
        end else begin : g_regs
            logic [P_DEPTH-1:0][P_DATA_WIDTH-1:0] data_q;
            logic [P_DEPTH-1:0]                   valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= '0;
                end else begin
                    valid_q[0] <= src_valid;
                    if (src_valid) data_q[0] <= src_data;
                    for (int i = 1; i < int'(P_DEPTH); i++) begin
                        valid_q[i] <= valid_q[i-1];
                        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
                    end
                end
            end

            assign dst_data  = data_q[P_DEPTH-1];
            assign dst_valid = valid_q[P_DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ram_2p_bm_pipe.sv
// Single-clock true dual-port RAM with per-bit write mask, read-valid pipeline and collision flag.
// Optional post-reset array clear is compiled in with `define RAM_2P_INIT_CLEAR_EN.
module ram_2p_bm_pipe
    import ram_2p_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = 20,
    parameter int unsigned P_ADDR_WIDTH = 9,
    parameter int unsigned P_COUNT      = 512,
    parameter int unsigned P_OUT_REG    = 1,
    parameter int unsigned P_RW_MODE    = 0
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    A_CS_I,
    input  logic                    A_WE_I,
    input  logic                    A_RE_I,
    input  logic [P_ADDR_WIDTH-1:0] A_ADDR_I,
    input  logic [P_DATA_WIDTH-1:0] A_DW_I,
    input  logic [P_DATA_WIDTH-1:0] A_BM_I,
    output logic [P_DATA_WIDTH-1:0] A_DR_O,
    output logic                    A_DV_O,
    input  logic                    B_CS_I,
    input  logic                    B_WE_I,
    input  logic                    B_RE_I,
    input  logic [P_ADDR_WIDTH-1:0] B_ADDR_I,
    input  logic [P_DATA_WIDTH-1:0] B_DW_I,
    input  logic [P_DATA_WIDTH-1:0] B_BM_I,
    output logic [P_DATA_WIDTH-1:0] B_DR_O,
    output logic                    B_DV_O,
    output logic                    BUSY_O,
    output logic                    COLL_O
);

    localparam int unsigned AW = P_ADDR_WIDTH;
    localparam int unsigned DW = P_DATA_WIDTH;
    localparam logic [AW:0] COUNT_EXT = (AW+1)'(P_COUNT);

    logic [DW-1:0] mem [P_COUNT];

    logic          busy_c, clr_we_c;
    logic [AW-1:0] clr_addr_c;

`ifdef RAM_2P_INIT_CLEAR_EN
    clr_state_t    state, state_nx;
    logic [AW-1:0] clr_cnt, clr_cnt_nx;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    // Zero one word per cycle, leave CLEAR on the edge writing the last word.
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        clr_we_c   = 1'b0;
        case (state)
            IDLE: ;
            CLEAR: begin
                clr_we_c = 1'b1;
                if (clr_cnt == AW'(P_COUNT - 1)) begin
                    state_nx   = IDLE;
                    clr_cnt_nx = '0;
                end else begin
                    clr_cnt_nx = clr_cnt + AW'(1);
                end
            end
        endcase
    end

    assign busy_c     = (state == CLEAR);
    assign clr_addr_c = clr_cnt;
`else
    assign busy_c     = 1'b0;
    assign clr_we_c   = 1'b0;
    assign clr_addr_c = '0;
`endif

    logic          wr_a_c, rd_a_c, wr_b_c, rd_b_c;
    logic          in_a_c, in_b_c, same_c, coll_c;
    logic [DW-1:0] old_a_c, old_b_c, base_a_c, wdat_a_c, wdat_b_c, rdat_a_c, rdat_b_c;

    // Access qualification, collision detection and merged write/read data.
    always_comb begin
        wr_a_c   = A_CS_I & A_WE_I & ~busy_c;
        rd_a_c   = A_CS_I & A_RE_I & ~A_WE_I & ~busy_c;
        wr_b_c   = B_CS_I & B_WE_I & ~busy_c;
        rd_b_c   = B_CS_I & B_RE_I & ~B_WE_I & ~busy_c;
        in_a_c   = {1'b0, A_ADDR_I} < COUNT_EXT;
        in_b_c   = {1'b0, B_ADDR_I} < COUNT_EXT;
        same_c   = in_a_c & in_b_c & (A_ADDR_I == B_ADDR_I);
        old_a_c  = in_a_c ? mem[A_ADDR_I] : '0;
        old_b_c  = in_b_c ? mem[B_ADDR_I] : '0;
        wdat_b_c = DW'(merge_bm(MERGE_W'(old_b_c), MERGE_W'(B_DW_I), MERGE_W'(B_BM_I)));
        // A is merged on top of B so A's masked bits win on a write/write collision.
        base_a_c = (same_c & wr_b_c) ? wdat_b_c : old_a_c;
        wdat_a_c = DW'(merge_bm(MERGE_W'(base_a_c), MERGE_W'(A_DW_I), MERGE_W'(A_BM_I)));
        rdat_a_c = old_a_c;
        rdat_b_c = old_b_c;
        if (P_RW_MODE == RW_WRITE_THROUGH) begin
            if (same_c & wr_b_c) rdat_a_c = wdat_b_c;
            if (same_c & wr_a_c) rdat_b_c = wdat_a_c;
        end
        coll_c = same_c & (wr_a_c | wr_b_c) & (wr_a_c | rd_a_c) & (wr_b_c | rd_b_c);
    end

    always_ff @(posedge CLK_I) begin
        if (clr_we_c) mem[clr_addr_c] <= '0;
        if (wr_b_c && in_b_c) mem[B_ADDR_I] <= wdat_b_c;
        if (wr_a_c && in_a_c) mem[A_ADDR_I] <= wdat_a_c;
    end

    logic          a_vld_q, b_vld_q, coll_q;
    logic [DW-1:0] a_dat_q, b_dat_q;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            a_dat_q <= '0;
            b_dat_q <= '0;
            coll_q  <= 1'b0;
        end else begin
            a_vld_q <= rd_a_c;
            b_vld_q <= rd_b_c;
            if (rd_a_c) a_dat_q <= rdat_a_c;
            if (rd_b_c) b_dat_q <= rdat_b_c;
            coll_q  <= coll_c;
        end
    end

    ram_2p_out_pipe #(.P_DATA_WIDTH(DW), .P_DEPTH(P_OUT_REG)) u_pipe_a (
        .clk      (CLK_I),
        .rst      (RST_I),
        .src_data (a_dat_q),
        .src_valid(a_vld_q),
        .dst_data (A_DR_O),
        .dst_valid(A_DV_O)
    );

    ram_2p_out_pipe #(.P_DATA_WIDTH(DW), .P_DEPTH(P_OUT_REG)) u_pipe_b (
        .clk      (CLK_I),
        .rst      (RST_I),
        .src_data (b_dat_q),
        .src_valid(b_vld_q),
        .dst_data (B_DR_O),
        .dst_valid(B_DV_O)
    );

    assign BUSY_O = busy_c;
    assign COLL_O = coll_q;

endmodule
